frame_array_tx: RTL and testbench



---
 rtl/frame_array_pkg.sv | 30 +++
 rtl/frame_array_tx_if.sv | 12 +
 rtl/frame_array_tx_ckgen.sv | 28 ++
 rtl/frame_array_tx.sv | 149 ++++++++++++++
 tb/tb_frame_array_tx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/frame_array_pkg.sv
// Shared types for the frame-array link (transmitter and receiver).
// Word type, default frame bounds, state encoding and index-to-row/column mapping.
package frame_array_pkg;

  typedef logic [1:4][0:3] fa_word_t;

  localparam int FA_ROW_LO = 2;
  localparam int FA_ROW_HI = 4;
  localparam int FA_COL_LO = 0;
  localparam int FA_COL_HI = 1;

  typedef enum logic [1:0] {IDLE, SEND, TRAIL} fa_state_e;

  typedef struct packed {
    int row;
    int col;
  } fa_rc_t;

  // Row-major walk from the low corner: idx 0 is [row_lo][col_lo].
  function automatic fa_rc_t fa_index_to_rc(input int idx, input int row_lo,
                                            input int col_lo, input int col_hi);
    fa_rc_t rc;
    int     w;
    w      = col_hi - col_lo + 1;
    rc.row = row_lo + idx / w;
    rc.col = col_lo + idx % w;
    return rc;
  endfunction

endpackage

// File: rtl/frame_array_tx_if.sv
// Word-link handshake between frame transmitter and receiver.
interface frame_array_tx_if;
  import frame_array_pkg::*;

  fa_word_t tx_data;
  logic     tx_valid;
  logic     tx_ready;
  logic     tx_last;

  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/frame_array_tx_ckgen.sv
// Running XOR of the data words of one frame; cleared when a frame is captured.
module frame_array_tx_ckgen
  import frame_array_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     upd,
  input  fa_word_t din,
  output fa_word_t acc
);

  fa_word_t acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (upd) acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/frame_array_tx.sv
// Frame-array transmitter: captures a 2-D frame on load and streams it row-major.
// Define FRAME_ARRAY_TX_CHECKSUM_EN to append an XOR trailer word carrying tx_last.
module frame_array_tx
  import frame_array_pkg::*;
#(
  parameter int ROW_LO = FA_ROW_LO,
  parameter int ROW_HI = FA_ROW_HI,
  parameter int COL_LO = FA_COL_LO,
  parameter int COL_HI = FA_COL_HI
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  fa_word_t              frame_in [ROW_LO:ROW_HI][COL_LO:COL_HI],
  frame_array_tx_if.master      tx,
  output bit [4:2]              status,
  output int                    sent_count
);

  localparam int N     = (ROW_HI - ROW_LO + 1) * (COL_HI - COL_LO + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
`ifdef FRAME_ARRAY_TX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  // Flatten the 2-D input into transmit order so the datapath is a plain mux.
  fa_word_t frame_flat [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    if (i < N) begin : g_in
      localparam fa_rc_t RC = fa_index_to_rc(i, ROW_LO, COL_LO, COL_HI);
      assign frame_flat[i] = frame_in[RC.row][RC.col];
    end else begin : g_pad
      assign frame_flat[i] = '0;
    end
  end

  fa_state_e        state_q, state_d;
  fa_word_t         frame_q [DEPTH];
  fa_word_t         frame_d [DEPTH];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  int               cnt_q, cnt_d;
  logic             hs, fin;
  fa_word_t         word;

  assign hs   = valid_q && tx.tx_ready;
  assign word = frame_q[idx_q];

`ifdef FRAME_ARRAY_TX_CHECKSUM_EN
  fa_word_t ck_acc;
  frame_array_tx_ckgen u_ckgen (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE && load),
    .upd (hs && state_q == SEND),
    .din (word),
    .acc (ck_acc)
  );
  assign tx.tx_data = !valid_q ? '0 : (state_q == TRAIL) ? ck_acc : word;
`else
  assign tx.tx_data = valid_q ? word : '0;
`endif

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        frame_d = frame_flat;
        state_d = SEND;
        idx_d   = '0;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        last_d  = (N == 1) && !CK_EN;
      end
      SEND: begin
        if (load) ovr_d = 1'b1;
        if (hs) begin
          if (idx_q != LAST_IDX) begin
            idx_d  = idx_q + 1'b1;
            last_d = !CK_EN && (idx_q + 1'b1 == LAST_IDX);
          end else if (CK_EN) begin
            state_d = TRAIL;
            last_d  = 1'b1;
          end else begin
            fin = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (load) ovr_d = 1'b1;
        if (hs)   fin   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A load coinciding with the final handshake was already flagged above and is dropped.
    if (fin) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      cnt_d   = (cnt_q == 32'h7FFF_FFFF) ? 0 : cnt_q + 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) frame_q[i] <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= 0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign status      = {busy_q, done_q, ovr_q};
  assign sent_count  = cnt_q;

endmodule

// File: tb/tb_frame_array_tx.sv
// Randomized bench for frame_array_tx: a row-major word-list model checks every presented word.
module tb_frame_array_tx;
  import frame_array_pkg::*;

  localparam int RL = 2, RH = 4, CL = 0, CH = 1;
  localparam int N  = (RH - RL + 1) * (CH - CL + 1);
`ifdef FRAME_ARRAY_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0, load1 = 1'b0;
  always #5 clk = ~clk;

  frame_array_tx_if bus ();
  frame_array_tx_if bus1 ();
  fa_word_t frame_in [RL:RH][CL:CH];
  fa_word_t frame1   [0:0][0:0];
  fa_word_t nf       [RL:RH][CL:CH];
  bit [4:2] status, status1;
  int       sent_count, sent1;

  int       checks = 0, errors = 0, exp_sent = 0;
  bit       exp_ovr = 1'b0;
  fa_word_t expq [$];

  frame_array_tx #(.ROW_LO(RL), .ROW_HI(RH), .COL_LO(CL), .COL_HI(CH)) dut (
    .clk(clk), .rst(rst), .load(load), .frame_in(frame_in),
    .tx(bus), .status(status), .sent_count(sent_count));

  frame_array_tx #(.ROW_LO(0), .ROW_HI(0), .COL_LO(0), .COL_HI(0)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .frame_in(frame1),
    .tx(bus1), .status(status1), .sent_count(sent1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ramp_frame();
    for (int r = RL; r <= RH; r++)
      for (int c = CL; c <= CH; c++) nf[r][c] = 16'(16'h0100 * r + c);
  endtask

  task automatic rand_frame();
    for (int r = RL; r <= RH; r++)
      for (int c = CL; c <= CH; c++) nf[r][c] = 16'($urandom);
  endtask

  task automatic build_exp();
    fa_word_t x;
    x = '0;
    expq.delete();
    for (int r = RL; r <= RH; r++)
      for (int c = CL; c <= CH; c++) begin
        expq.push_back(nf[r][c]);
        x = x ^ nf[r][c];
      end
    if (CK) expq.push_back(x);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_frame(input int pct, input int load_at, input int abort_at);
    int words = 0;
    int cyc = 0;
    bit ld;
    build_exp();
    frame_in = nf;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("first_valid", bus.tx_valid, 1);
    chk("busy_start", status[4], 1);
    while (expq.size() > 0 && cyc < 200) begin
      ld = (words == load_at);
      bus.tx_ready = ld || ($urandom_range(99) < pct);
      if (ld) begin
        load = 1'b1;
        for (int r = RL; r <= RH; r++)
          for (int c = CL; c <= CH; c++) frame_in[r][c] = 16'($urandom);
        exp_ovr = 1'b1;
      end
      if (words == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", bus.tx_valid, 0);
        chk("abort_count", sent_count, 0);
        chk("abort_status", status, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_sent = 0;
        exp_ovr = 1'b0;
        return;
      end
      chk("valid", bus.tx_valid, 1);
      chk("data", bus.tx_data, expq[0]);
      chk("last", bus.tx_last, expq.size() == 1);
      if (bus.tx_ready) begin
        void'(expq.pop_front());
        words++;
      end
      @(negedge clk);
      load = 1'b0;
      cyc++;
    end
    chk("frame_timeout", cyc < 200, 1);
    exp_sent++;
    chk("end_valid", bus.tx_valid, 0);
    chk("end_last", bus.tx_last, 0);
    chk("done_pulse", status[3], 1);
    chk("busy_end", status[4], 0);
    chk("sent_count", sent_count, exp_sent);
    chk("overrun", status[2], exp_ovr);
    @(negedge clk);
    chk("done_clear", status[3], 0);
  endtask

  initial begin
    int bc;
    bus.tx_ready  = 1'b0;
    bus1.tx_ready = 1'b0;
    frame1[0][0]  = '0;
    ramp_frame();
    frame_in = nf;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_last", bus.tx_last, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_status", status, 0);
    chk("rst_count", sent_count, 0);
    rst = 1'b0;
    @(negedge clk);

    ramp_frame(); run_frame(100, -1, -1);
    ramp_frame(); run_frame(50, -1, -1);

    // Load mid-frame is ignored; no second frame follows.
    rand_frame(); run_frame(60, 2, -1);
    for (int k = 0; k < 3; k++) begin
      chk("no_second_frame", bus.tx_valid, 0);
      @(negedge clk);
    end

    // Reset during word 4, then a clean full frame.
    ramp_frame(); run_frame(100, -1, 3);
    ramp_frame(); run_frame(100, -1, -1);

    // Load coinciding with the final handshake, then an immediate new frame.
    rand_frame(); run_frame(70, N - 1 + int'(CK), -1);
    for (int k = 0; k < 4; k++) begin
      rand_frame();
      run_frame(int'($urandom_range(100, 20)), -1, -1);
    end

    // Single-element frame.
    frame1[0][0]  = 16'hBEEF;
    bus1.tx_ready = 1'b1;
    load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    bc = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        chk("n1_valid", bus1.tx_valid, 1);
        chk("n1_data", bus1.tx_data, 16'hBEEF);
        chk("n1_last", bus1.tx_last, !CK);
      end
      if (CK && k == 1) begin
        chk("n1_trailer", bus1.tx_data, 16'hBEEF);
        chk("n1_trailer_last", bus1.tx_last, 1);
      end
      if (status1[4]) bc++;
      @(negedge clk);
    end
    chk("n1_busy_cycles", bc, CK ? 2 : 1);
    chk("n1_count", sent1, 1);
    chk("n1_valid_end", bus1.tx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
